// File: rtl/prm_oblgc_edge_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prm_oblgc_edge_chk : programmable product-term checker over sample edges   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module prm_oblgc_edge_chk #(
   parameter int IN_W      = 15,
   parameter int NUM_TERMS = 32,
   parameter int CNT_W     = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_TERMS)-1:0] cfg_addr,
   input  logic [IN_W-1:0]              cfg_care,
   input  logic [IN_W-1:0]              cfg_val,
   input  logic                         cfg_en,
   output logic                         cfg_ack,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [IN_W-1:0]              s_code,
   input  logic                         s_last,
   output logic                         r_valid,
   input  logic                         r_ready,
   output logic                         r_blocked,
   output logic [CNT_W-1:0]             r_count,
   output logic [CNT_W-1:0]             r_first
);

   localparam int AW = $clog2(NUM_TERMS);
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   xfer;
   logic                   cfg_take;
   logic [NUM_TERMS-1:0]   term_hit;
   logic                   sample_hit;

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_match_q, s1_match_d;
   logic                   blocked_q, blocked_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       first_q, first_d;
   logic                   cfg_ack_q, cfg_ack_d;

   assign xfer = s_valid && s_ready;

   // Writes only land while the edge is empty, so an edge never sees a mix of old and new terms.
   assign cfg_take = cfg_we && (state_q == ST_ACCUM) && (count_q == '0)
                     && !s1_valid_q && !xfer;

   generate
      for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
         localparam logic [AW-1:0] c_idx = AW'(t);
         logic [IN_W-1:0] care_q, care_d;
         logic [IN_W-1:0] val_q, val_d;
         logic            en_q, en_d;

         always_comb begin
            care_d = care_q;
            val_d  = val_q;
            en_d   = en_q;
            if (cfg_take && (cfg_addr == c_idx)) begin
               care_d = cfg_care;
               val_d  = cfg_val;
               en_d   = cfg_en;
            end
         end

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               care_q <= '0;
               val_q  <= '0;
               en_q   <= 1'b0;
            end else begin
               care_q <= care_d;
               val_q  <= val_d;
               en_q   <= en_d;
            end
         end

         assign term_hit[t] = en_q && (((s_code ^ val_q) & care_q) == '0);
      end
   endgenerate

   assign sample_hit = |term_hit;

   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      r_valid = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            s_ready = 1'b1;
            if (s_valid && s_last) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RESULT;
         end
         ST_RESULT: begin
            r_valid = 1'b1;
            if (r_ready) begin
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_comb begin
      s1_valid_d = xfer;
      s1_match_d = xfer && sample_hit;
      cfg_ack_d  = cfg_take;
   end

   // The pre-increment count is the zero-based index of the sample now leaving stage 1.
   always_comb begin
      blocked_d = blocked_q;
      count_d   = count_q;
      first_d   = first_q;
      if ((state_q == ST_RESULT) && r_ready) begin
         blocked_d = 1'b0;
         count_d   = '0;
         first_d   = c_cnt_max;
      end else if (s1_valid_q) begin
         count_d = (count_q == c_cnt_max) ? c_cnt_max : count_q + CNT_W'(1);
         if (s1_match_q && !blocked_q) begin
            blocked_d = 1'b1;
            first_d   = count_q;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_ACCUM;
         s1_valid_q <= 1'b0;
         s1_match_q <= 1'b0;
         blocked_q  <= 1'b0;
         count_q    <= '0;
         first_q    <= c_cnt_max;
         cfg_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_match_q <= s1_match_d;
         blocked_q  <= blocked_d;
         count_q    <= count_d;
         first_q    <= first_d;
         cfg_ack_q  <= cfg_ack_d;
      end
   end

   assign cfg_ack   = cfg_ack_q;
   assign r_blocked = blocked_q;
   assign r_count   = count_q;
   assign r_first   = first_q;

endmodule
`default_nettype wire
